// File: rtl/sha1_pkg.sv
// rtl/sha1_pkg.sv - shared states and constants for the SHA-1 message padder
package sha1_pkg;

  typedef enum logic [2:0] {
    ST_DATA,
    ST_MARK,
    ST_ZERO,
    ST_LEN_HI,
    ST_LEN_LO
  } pad_state_e;

  localparam logic [31:0] PAD_MARK      = 32'h8000_0000;
  localparam int          WORDS_PER_BLK = 16;
  localparam logic [3:0]  LEN_IDX_HI    = 4'd14;
  localparam logic [3:0]  IDX_LAST      = 4'(WORDS_PER_BLK - 1);

  // Bits contributed by the final word; in_bytes==0 means a full word.
  function automatic logic [6:0] last_word_bits(input logic [1:0] nbytes);
    return (nbytes == 2'd0) ? 7'd32 : {2'b00, nbytes, 3'b000};
  endfunction

endpackage

// File: rtl/sha1_pad_merge.sv
// rtl/sha1_pad_merge.sv - places the 0x80 marker after the valid bytes of a partial final word
module sha1_pad_merge
  import sha1_pkg::*;
(
  input  logic [31:0] in_word,
  input  logic [1:0]  in_bytes,
  output logic [31:0] merged_word
);

  always_comb begin
    merged_word = in_word;
    case (in_bytes)
      2'd1:    merged_word = {in_word[31:24], PAD_MARK[31:24], 16'h0000};
      2'd2:    merged_word = {in_word[31:16], PAD_MARK[31:24], 8'h00};
      2'd3:    merged_word = {in_word[31:8],  PAD_MARK[31:24]};
      default: merged_word = in_word;
    endcase
  end

endmodule

// File: rtl/sha1_msg_padder.sv
// rtl/sha1_msg_padder.sv - streams message words out as padded 512-bit SHA-1 blocks
// Optional block counter port blk_cnt enabled by SHA1_PAD_BLKCNT_EN.
module sha1_msg_padder
  import sha1_pkg::*;
#(
  parameter int LEN_W = 64
) (
  input  logic        clk,
  input  logic        r,
  input  logic [31:0] in_word,
  input  logic        in_valid,
  input  logic        in_last,
  input  logic [1:0]  in_bytes,
  output logic        in_ready,
  output logic [31:0] out_word,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_blk_last,
  output logic        out_msg_last
`ifdef SHA1_PAD_BLKCNT_EN
  ,
  output logic [15:0] blk_cnt
`endif
);

  pad_state_e       state_q, state_d;
  logic [3:0]       idx_q, idx_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [31:0]      out_word_q, out_word_d;
  logic             out_valid_q, out_valid_d;
  logic             out_blk_last_q, out_blk_last_d;
  logic             out_msg_last_q, out_msg_last_d;

  logic             can_load;
  logic             in_xfer;
  logic             load;
  logic [31:0]      load_word;
  logic             load_msg_last;
  logic             marker_to_len;
  logic [31:0]      merged_word;
  logic [63:0]      len_ext;

  sha1_pad_merge u_merge (
    .in_word     (in_word),
    .in_bytes    (in_bytes),
    .merged_word (merged_word)
  );

  assign can_load      = !out_valid_q || out_ready;
  assign in_ready      = (state_q == ST_DATA) && can_load;
  assign in_xfer       = in_valid && in_ready;
  // Once the marker or a fill word sits at idx 13, the length fits in this block.
  assign marker_to_len = (idx_q == LEN_IDX_HI - 4'd1);
  assign len_ext       = 64'(len_q);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    len_d          = len_q;
    out_word_d     = out_word_q;
    out_valid_d    = out_valid_q;
    out_blk_last_d = out_blk_last_q;
    out_msg_last_d = out_msg_last_q;
    load           = 1'b0;
    load_word      = 32'h0000_0000;
    load_msg_last  = 1'b0;

    case (state_q)
      ST_DATA: begin
        if (in_xfer) begin
          load = 1'b1;
          if (in_last) begin
            len_d = len_q + LEN_W'(last_word_bits(in_bytes));
            if (in_bytes == 2'd0) begin
              load_word = in_word;
              state_d   = ST_MARK;
            end else begin
              load_word = merged_word;
              state_d   = marker_to_len ? ST_LEN_HI : ST_ZERO;
            end
          end else begin
            len_d     = len_q + LEN_W'(7'd32);
            load_word = in_word;
          end
        end
      end
      ST_MARK: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = PAD_MARK;
          state_d   = marker_to_len ? ST_LEN_HI : ST_ZERO;
        end
      end
      ST_ZERO: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = 32'h0000_0000;
          state_d   = marker_to_len ? ST_LEN_HI : ST_ZERO;
        end
      end
      ST_LEN_HI: begin
        if (can_load) begin
          load      = 1'b1;
          load_word = len_ext[63:32];
          state_d   = ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (can_load) begin
          load          = 1'b1;
          load_word     = len_ext[31:0];
          load_msg_last = 1'b1;
          len_d         = '0;
          state_d       = ST_DATA;
        end
      end
      default: state_d = ST_DATA;
    endcase

    // idx tracks the slot of the word being loaded; each load leaves exactly once.
    if (load) begin
      out_word_d     = load_word;
      out_valid_d    = 1'b1;
      out_blk_last_d = (idx_q == IDX_LAST);
      out_msg_last_d = load_msg_last;
      idx_d          = idx_q + 4'd1;
    end else if (can_load) begin
      out_valid_d    = 1'b0;
      out_blk_last_d = 1'b0;
      out_msg_last_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      state_q        <= ST_DATA;
      idx_q          <= 4'd0;
      len_q          <= '0;
      out_word_q     <= 32'h0000_0000;
      out_valid_q    <= 1'b0;
      out_blk_last_q <= 1'b0;
      out_msg_last_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      len_q          <= len_d;
      out_word_q     <= out_word_d;
      out_valid_q    <= out_valid_d;
      out_blk_last_q <= out_blk_last_d;
      out_msg_last_q <= out_msg_last_d;
    end
  end

  assign out_word     = out_word_q;
  assign out_valid    = out_valid_q;
  assign out_blk_last = out_blk_last_q;
  assign out_msg_last = out_msg_last_q;

`ifdef SHA1_PAD_BLKCNT_EN
  logic [15:0] blk_cnt_q, blk_cnt_d;

  always_comb begin
    blk_cnt_d = blk_cnt_q;
    if (out_valid_q && out_ready && out_blk_last_q) begin
      blk_cnt_d = blk_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (r) begin
      blk_cnt_q <= 16'd0;
    end else begin
      blk_cnt_q <= blk_cnt_d;
    end
  end

  assign blk_cnt = blk_cnt_q;
`endif

endmodule
